// File: rtl/d2s_channel_src.sv
// d2s_channel_src
// Deterministic-to-stochastic channel source for an equality node. Turns a
// W-bit channel probability into the stochastic bit stream c, drives the
// edge-memory address EM_SEL, and walks the node through an edge-memory fill
// phase (INIT high) followed by a fixed-length decoding phase.
// Every output is registered from the state of the previous cycle, so the
// outputs trail the internal state by exactly one clock.

module d2s_channel_src #(
   parameter int              W        = 8,
   parameter int              EM_AW    = 3,
   parameter int              INIT_CYC = 8,
   parameter int              DEC_CYC  = 1024,
   parameter logic [W-1:0]    SEED_C   = 8'hA5,
   parameter logic [15:0]     SEED_A   = 16'hACE1
) (
   input  logic             CLK_D2S,
   input  logic             RST,
   input  logic             START,
   input  logic [W-1:0]     P,
   output logic             c,
   output logic             INIT,
   output logic [EM_AW-1:0] EM_SEL,
   output logic             BUSY,
   output logic             DONE,
   output logic [15:0]      CYC
);

   // Maximal-length Fibonacci tap masks (bit n-1 set for tap n).
   function automatic logic [31:0] tap_table(input int w);
      logic [31:0] m;
      case (w)
         3:       m = 32'h0000_0006;
         4:       m = 32'h0000_000C;
         5:       m = 32'h0000_0014;
         6:       m = 32'h0000_0030;
         7:       m = 32'h0000_0060;
         8:       m = 32'h0000_00B8;
         9:       m = 32'h0000_0110;
         10:      m = 32'h0000_0240;
         11:      m = 32'h0000_0500;
         12:      m = 32'h0000_0829;
         13:      m = 32'h0000_100D;
         14:      m = 32'h0000_2015;
         15:      m = 32'h0000_6000;
         16:      m = 32'h0000_D008;
         default: m = (32'h0000_0001 << (w - 1)) | (32'h0000_0001 << (w - 2));
      endcase
      return m;
   endfunction

   localparam logic [31:0] TAP_C_FULL = tap_table(W);
   localparam logic [W-1:0] TAP_C     = TAP_C_FULL[W-1:0];
   // Taps 16,14,13,11 for the address generator.
   localparam logic [15:0] TAP_A      = 16'hB400;
   localparam logic [15:0] FILL_LAST  = 16'(INIT_CYC - 1);
   localparam logic [15:0] RUN_LAST   = 16'(DEC_CYC - 1);

   // Parity of the tapped bits is the LFSR feedback.
   function automatic logic parity_c(input logic [W-1:0] v);
      return ^(v & TAP_C);
   endfunction

   function automatic logic parity_a(input logic [15:0] v);
      return ^(v & TAP_A);
   endfunction

   function automatic logic [W-1:0] step_c(input logic [W-1:0] v);
      return {v[W-2:0], parity_c(v)};
   endfunction

   function automatic logic [15:0] step_a(input logic [15:0] v);
      return {v[14:0], parity_a(v)};
   endfunction

   // Phase counter increment that sticks at all-ones instead of wrapping.
   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : (v + 16'd1);
   endfunction

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_LOAD = 3'd1,
      ST_FILL = 3'd2,
      ST_RUN  = 3'd3,
      ST_DONE = 3'd4
   } state_t;

   state_t         state_r;
   state_t         state_nxt_s;
   logic [15:0]    cyc_r;
   logic [15:0]    cyc_nxt_s;
   logic [W-1:0]   p_reg_r;
   logic           load_p_s;
   logic [W-1:0]   lfsr_c_r;
   logic [W-1:0]   lfsr_c_nxt_s;
   logic [15:0]    lfsr_a_r;
   logic [15:0]    lfsr_a_nxt_s;
   logic           active_s;
   logic           busy_s;

   assign active_s = (state_r == ST_FILL) || (state_r == ST_RUN);
   assign busy_s   = (state_r == ST_LOAD) || active_s;

   // Next-state, phase counter and LFSR update decisions
   always_comb begin
      state_nxt_s  = state_r;
      cyc_nxt_s    = cyc_r;
      lfsr_c_nxt_s = lfsr_c_r;
      lfsr_a_nxt_s = lfsr_a_r;
      load_p_s     = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (START) begin
               state_nxt_s = ST_LOAD;
               load_p_s    = 1'b1;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_LOAD: begin
            state_nxt_s  = ST_FILL;
            cyc_nxt_s    = 16'd0;
            lfsr_c_nxt_s = SEED_C;
            lfsr_a_nxt_s = SEED_A;
         end
         ST_FILL: begin
            lfsr_c_nxt_s = step_c(lfsr_c_r);
            lfsr_a_nxt_s = step_a(lfsr_a_r);
            if (cyc_r == FILL_LAST) begin
               state_nxt_s = ST_RUN;
               cyc_nxt_s   = 16'd0;
            end else begin
               cyc_nxt_s   = sat_inc(cyc_r);
            end
         end
         ST_RUN: begin
            lfsr_c_nxt_s = step_c(lfsr_c_r);
            lfsr_a_nxt_s = step_a(lfsr_a_r);
            if (cyc_r == RUN_LAST) begin
               state_nxt_s = ST_DONE;
               cyc_nxt_s   = 16'd0;
            end else begin
               cyc_nxt_s   = sat_inc(cyc_r);
            end
         end
         ST_DONE: begin
            state_nxt_s = ST_IDLE;
            cyc_nxt_s   = 16'd0;
         end
         default: begin
            state_nxt_s  = ST_IDLE;
            cyc_nxt_s    = 16'd0;
            lfsr_c_nxt_s = SEED_C;
            lfsr_a_nxt_s = SEED_A;
         end
      endcase
   end

   // State, counter, LFSR and latched-probability registers
   always_ff @(posedge CLK_D2S) begin
      if (RST) begin
         state_r  <= ST_IDLE;
         cyc_r    <= 16'd0;
         lfsr_c_r <= SEED_C;
         lfsr_a_r <= SEED_A;
         p_reg_r  <= {W{1'b0}};
      end else begin
         state_r  <= state_nxt_s;
         cyc_r    <= cyc_nxt_s;
         lfsr_c_r <= lfsr_c_nxt_s;
         lfsr_a_r <= lfsr_a_nxt_s;
         if (load_p_s) begin
            p_reg_r <= P;
         end else begin
            p_reg_r <= p_reg_r;
         end
      end
   end

   // Register all node-facing outputs from the current state
   always_ff @(posedge CLK_D2S) begin
      if (RST) begin
         c      <= 1'b0;
         INIT   <= 1'b0;
         EM_SEL <= {EM_AW{1'b0}};
         BUSY   <= 1'b0;
         DONE   <= 1'b0;
         CYC    <= 16'd0;
      end else begin
         // The LFSR never holds zero, so P=0 gives all zeros and P=all-ones gives all ones.
         c      <= active_s && (lfsr_c_r <= p_reg_r);
         INIT   <= (state_r == ST_FILL);
         EM_SEL <= active_s ? lfsr_a_r[EM_AW-1:0] : {EM_AW{1'b0}};
         BUSY   <= busy_s;
         DONE   <= (state_r == ST_DONE);
         CYC    <= cyc_r;
      end
   end

endmodule
